display_scan: RTL and testbench
===============================

// Module: display_scan
// PURPOSE
//  Time-multiplexed digit scanner directly upstream of the hex-to-7-segment decoder.
//  Holds a 16-bit value, steps through NUM_DIGITS digit slots and drives one active-low
//  anode per slot. It presents that slot's nibble on n_out and the decimal point on dp.
//  Adds tear-free value update, an anti-ghosting guard, leading-zero blanking and a
//  frame-done pulse.
// PARAMETERS
//  NUM_DIGITS   4   digit slots; value_in width = 4*NUM_DIGITS
//  SCAN_W       16  prescaler width; one digit slot lasts 2**SCAN_W clk cycles
//  GUARD_CYCLES 64  cycles at the start of each slot with all anodes off (< 2**SCAN_W)
// PORTS
//  clk        in   1     system clock, single clock domain
//  rst_n      in   1     asynchronous assert, active-low reset
//  value_in   in   16    value to display; nibble d goes to digit d (digit 0 = LSD)
//  load       in   1     capture value_in into the pending register this edge
//  digit_en   in   4     per-digit enable; 0 = digit always dark
//  dp_in      in   4     per-digit decimal point request, active-high
//  blank_lz   in   1     1 = blank leading zero digits
//  an         out  4     anode drive, active-low, at most one bit low
//  n_out      out  4     nibble for current slot, feeds hex7seg n
//  dp         out  1     decimal point, active-low
//  frame_done out  1     1-cycle pulse at the end of the last digit slot
// BEHAVIOUR
//  - Reset (async, rst_n=0): presc=0, idx=0, pend=0, active=0.
//    Outputs: an=4'b1111, n_out=0, dp=1, frame_done=0.
//  - All outputs are functions of flops only; there is no input-to-output combinational path.
//  - presc increments every cycle and wraps at 2**SCAN_W-1. tc = (presc == all ones).
//  - On tc: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1. frame_done is registered and equals
//    1 in the cycle after tc with idx == NUM_DIGITS-1.
//  - load=1: pend <= value_in. pend does not reach the display until a frame boundary.
//  - Frame boundary (tc and idx == NUM_DIGITS-1): active <= load ? value_in : pend.
//    A load coinciding with the boundary is displayed in the new frame.
//  - n_out = active[4*idx +: 4]. It is valid even while the anode is dark.
//  - Digit idx is dark when any of the following holds:
//    * presc < GUARD_CYCLES
//    * digit_en[idx] = 0
//    * it is lz-blanked: blank_lz=1, idx != 0, and nibbles idx..NUM_DIGITS-1 of active
//      are all zero (digit 0 is never lz-blanked).
//  - Lit digit: an = ~(1 << idx), dp = ~dp_in[idx]. Dark digit: an = 4'b1111, dp = 1.
//  - Latency: a load becomes visible in the first slot of the next frame, i.e. within
//    NUM_DIGITS*2**SCAN_W + 1 cycles.
//  - Mid-operation reset returns immediately to the reset values and restarts at digit 0.
//  - Changes to digit_en, dp_in and blank_lz take effect the cycle after they are sampled.
// STRUCTURE
//  - Package display_pkg: NUM_DIGITS, NIBBLE_W=4, AN_OFF=4'b1111, DP_OFF=1'b1.
//  - Sub-module scan_prescaler: SCAN_W-bit counter with async active-low reset.
//    Outputs count and tc.
//  - display_scan contains the idx register, pend/active registers, blanking logic and
//    output registers.
//  - hex7seg is instantiated beside display_scan at top level, never inside it.
// TESTING (bench uses SCAN_W=3, GUARD_CYCLES=1 -> 8-cycle slots, 32-cycle frame)
//  1. Reset, release rst_n -> an=1111 at cycle 0. From cycle 1: an=1110, n_out=active[3:0]=0.
//     frame_done pulses once every 32 cycles.
//  2. load value_in=16'h12AB mid-frame -> display unchanged until the boundary.
//     Then n_out = B, A, 2, 1 with an = 1110, 1101, 1011, 0111.
//  3. load 16'h0042 with blank_lz=1 -> digits 0 and 1 lit (2, 4); digits 2 and 3 an=1111.
//     Load 16'h0000 -> only digit 0 lit, showing 0.
//  4. Load asserted exactly on the boundary cycle with 16'hBEEF -> the new frame shows
//     F, E, E, B; no frame shows stale pend.
//  5. digit_en=4'b0101, dp_in=4'b0100 -> digits 1 and 3 dark throughout.
//     dp=0 only during the lit part of digit 2.
//  6. Assert rst_n=0 during digit 2 -> an=1111, dp=1 asynchronously (same cycle).
//     After release, scanning restarts at digit 0 with active=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed digit scanner.
//
// NUM_DIGITS  number of digit slots scanned per frame
// NIBBLE_W    bits per displayed digit
// VALUE_W     width of the full displayed value
// IDX_W       width of the digit slot index
// AN_OFF      anode pattern with every digit dark (anodes are active-low)
// DP_OFF      decimal point off level (active-low)
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;
    localparam logic                  DP_OFF   = 1'b1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Active-low one-hot anode pattern selecting digit idx.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescaler that sets the length of one digit slot.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   count  out  current prescaler value, wraps from all ones to zero
//   tc     out  terminal count, high while count is all ones
module scan_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed digit scanner feeding a hex-to-7-segment decoder.
// Steps through the digit slots, drives one active-low anode per slot and
// presents that slot's nibble and decimal point. New values are staged in a
// pending register and only swapped into the displayed value at a frame
// boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   value_in    in   value to display, nibble d goes to digit d (digit 0 = LSD)
//   load        in   capture value_in into the pending register
//   digit_en    in   per-digit enable, 0 keeps the digit dark
//   dp_in       in   per-digit decimal point request, active-high
//   blank_lz    in   blank leading zero digits
//   an          out  anode drive, active-low, at most one bit low
//   n_out       out  nibble of the current slot (valid even while dark)
//   dp          out  decimal point, active-low
//   frame_done  out  one-cycle pulse after the last slot of a frame
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_W       = 16,
    parameter int GUARD_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] an,
    output logic [NIBBLE_W-1:0]   n_out,
    output logic                  dp,
    output logic                  frame_done
);

    logic [SCAN_W-1:0]     presc;
    logic                  tc;
    logic [IDX_W-1:0]      idx;
    logic [VALUE_W-1:0]    pend;
    logic [VALUE_W-1:0]    active;
    logic [NUM_DIGITS-1:0] en_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic                  blank_q;
    logic                  frame_end;

    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  in_guard;
    logic                  lz_dark;
    logic                  lit;

    scan_prescaler #(
        .W (SCAN_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .count (presc),
        .tc    (tc)
    );

    assign frame_end = tc && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tc) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load landing on the boundary edge bypasses pend so the new frame
    // never shows the value it is about to replace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            active <= '0;
        end else begin
            if (load) begin
                pend <= value_in;
            end
            if (frame_end) begin
                active <= load ? value_in : pend;
            end
        end
    end

    // Control inputs are registered so every output depends on flops only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= '0;
            dp_q    <= '0;
            blank_q <= 1'b0;
        end else begin
            en_q    <= digit_en;
            dp_q    <= dp_in;
            blank_q <= blank_lz;
        end
    end

    // upper_zero[d] is set when digit d and every more significant digit are zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (active[(NUM_DIGITS-1)*NIBBLE_W +: NIBBLE_W] == '0);
        for (int d = NUM_DIGITS - 2; d >= 0; d--) begin
            upper_zero[d] = upper_zero[d+1] && (active[d*NIBBLE_W +: NIBBLE_W] == '0);
        end
    end

    always_comb begin
        in_guard = (presc < SCAN_W'(GUARD_CYCLES));
        // Digit 0 always shows, so a zero value still displays "0".
        lz_dark  = blank_q && (idx != '0) && upper_zero[idx];
        lit      = !in_guard && en_q[idx] && !lz_dark;
    end

    always_comb begin
        an    = AN_OFF;
        dp    = DP_OFF;
        n_out = active[idx*NIBBLE_W +: NIBBLE_W];
        if (lit) begin
            an = anode_for(idx);
            dp = ~dp_q[idx];
        end
    end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  n_out;
    logic        dp;
    logic        frame_done;

    int vectors;
    int miscompares;

    display_scan #(
        .SCAN_W       (3),
        .GUARD_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .n_out      (n_out),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge where frame_done is high, i.e. slot 0, presc 0.
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        vectors++;
        if (!frame_done) begin
            miscompares++;
            $display("FAIL sync_frame: frame_done=%0b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    task automatic test_reset();
        int pulses;
        int first;
        #3;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL reset_an: got %b want 1111", an); end
        vectors++;
        if (n_out !== 4'h0) begin miscompares++; $display("FAIL reset_n_out: got %h want 0", n_out); end
        vectors++;
        if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b want 1", dp); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        step(2);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL cycle0_an: got %b want 1111", an); end
        step(1);
        vectors++;
        if (an !== 4'b1110) begin miscompares++; $display("FAIL cycle1_an: got %b want 1110", an); end
        vectors++;
        if (n_out !== 4'h0) begin miscompares++; $display("FAIL cycle1_n_out: got %h want 0", n_out); end
        pulses = 0;
        first  = -1;
        for (int k = 2; k <= 64; k++) begin
            step(1);
            if (frame_done === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (pulses != 2) begin miscompares++; $display("FAIL frame_done_count: got %0d want 2", pulses); end
        vectors++;
        if (first != 32) begin miscompares++; $display("FAIL frame_done_first: got cycle %0d want 32", first); end
    endtask

    task automatic test_load_midframe();
        logic [15:0] v;
        logic [3:0]  one;
        int cur;
        v   = 16'h12AB;
        one = 4'b0001;
        sync_frame();
        step(10);
        value_in = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        step(9);
        vectors++;
        if (n_out !== 4'h0) begin miscompares++; $display("FAIL midframe_hold_n_out: got %h want 0", n_out); end
        vectors++;
        if (an !== 4'b1011) begin miscompares++; $display("FAIL midframe_hold_an: got %b want 1011", an); end
        sync_frame();
        cur = 0;
        for (int d = 0; d < 4; d++) begin
            step(8 * d - cur);
            vectors++;
            if (an !== 4'b1111) begin miscompares++; $display("FAIL load_guard_an[%0d]: got %b want 1111", d, an); end
            vectors++;
            if (n_out !== v[4*d +: 4]) begin miscompares++; $display("FAIL load_guard_n_out[%0d]: got %h want %h", d, n_out, v[4*d +: 4]); end
            step(4);
            cur = 8 * d + 4;
            vectors++;
            if (an !== ~(one << d)) begin miscompares++; $display("FAIL load_an[%0d]: got %b want %b", d, an, ~(one << d)); end
            vectors++;
            if (n_out !== v[4*d +: 4]) begin miscompares++; $display("FAIL load_n_out[%0d]: got %h want %h", d, n_out, v[4*d +: 4]); end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2];
        logic [3:0]  masks [2];
        logic [3:0]  one;
        logic [3:0]  exp_an;
        int cur;
        vals[0]  = 16'h0042;  masks[0] = 4'b0011;
        vals[1]  = 16'h0000;  masks[1] = 4'b0001;
        one      = 4'b0001;
        blank_lz = 1'b1;
        for (int t = 0; t < 2; t++) begin
            sync_frame();
            value_in = vals[t];
            load     = 1'b1;
            step(1);
            load     = 1'b0;
            sync_frame();
            cur = 0;
            for (int d = 0; d < 4; d++) begin
                step(8 * d + 4 - cur);
                cur = 8 * d + 4;
                exp_an = masks[t][d] ? ~(one << d) : 4'b1111;
                vectors++;
                if (an !== exp_an) begin miscompares++; $display("FAIL lz_an[%0d][%0d]: got %b want %b", t, d, an, exp_an); end
                vectors++;
                if (n_out !== vals[t][4*d +: 4]) begin miscompares++; $display("FAIL lz_n_out[%0d][%0d]: got %h want %h", t, d, n_out, vals[t][4*d +: 4]); end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_boundary_load();
        logic [15:0] v;
        logic [3:0]  one;
        int cur;
        v   = 16'hBEEF;
        one = 4'b0001;
        sync_frame();
        step(1);
        value_in = 16'h5555;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        step(29);
        value_in = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        vectors++;
        if (frame_done !== 1'b1) begin miscompares++; $display("FAIL boundary_frame_done: got %b want 1", frame_done); end
        cur = 0;
        for (int d = 0; d < 4; d++) begin
            step(8 * d + 4 - cur);
            cur = 8 * d + 4;
            vectors++;
            if (n_out !== v[4*d +: 4]) begin miscompares++; $display("FAIL boundary_n_out[%0d]: got %h want %h", d, n_out, v[4*d +: 4]); end
            vectors++;
            if (an !== ~(one << d)) begin miscompares++; $display("FAIL boundary_an[%0d]: got %b want %b", d, an, ~(one << d)); end
        end
        step(32 - cur + 4);
        vectors++;
        if (n_out !== 4'hF) begin miscompares++; $display("FAIL next_frame_d0: got %h want f", n_out); end
        step(24);
        vectors++;
        if (n_out !== 4'hB) begin miscompares++; $display("FAIL next_frame_d3: got %h want b", n_out); end
    endtask

    task automatic test_enable_dp();
        logic [3:0] en;
        logic [3:0] dpm;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic       exp_dp;
        logic       lit;
        int dp_low;
        en       = 4'b0101;
        dpm      = 4'b0100;
        one      = 4'b0001;
        digit_en = en;
        dp_in    = dpm;
        sync_frame();
        dp_low = 0;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step(1);
            lit    = ((j % 8) != 0) && en[j / 8];
            exp_an = lit ? ~(one << (j / 8)) : 4'b1111;
            exp_dp = lit ? ~dpm[j / 8] : 1'b1;
            if (dp === 1'b0) dp_low++;
            vectors++;
            if (an !== exp_an) begin miscompares++; $display("FAIL en_an[j=%0d]: got %b want %b", j, an, exp_an); end
            vectors++;
            if (dp !== exp_dp) begin miscompares++; $display("FAIL en_dp[j=%0d]: got %b want %b", j, dp, exp_dp); end
        end
        vectors++;
        if (dp_low != 7) begin miscompares++; $display("FAIL dp_low_cycles: got %0d want 7", dp_low); end
        digit_en = 4'b1111;
        dp_in    = 4'b0000;
    endtask

    task automatic test_reset_midrun();
        sync_frame();
        step(20);
        vectors++;
        if (an !== 4'b1011) begin miscompares++; $display("FAIL pre_reset_an: got %b want 1011", an); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL async_reset_an: got %b want 1111", an); end
        vectors++;
        if (dp !== 1'b1) begin miscompares++; $display("FAIL async_reset_dp: got %b want 1", dp); end
        vectors++;
        if (n_out !== 4'h0) begin miscompares++; $display("FAIL async_reset_n_out: got %h want 0", n_out); end
        step(2);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL restart_cycle0_an: got %b want 1111", an); end
        step(1);
        vectors++;
        if (an !== 4'b1110) begin miscompares++; $display("FAIL restart_cycle1_an: got %b want 1110", an); end
        vectors++;
        if (n_out !== 4'h0) begin miscompares++; $display("FAIL restart_n_out: got %h want 0", n_out); end
        step(11);
        vectors++;
        if (an !== 4'b1101) begin miscompares++; $display("FAIL restart_d1_an: got %b want 1101", an); end
        vectors++;
        if (n_out !== 4'h0) begin miscompares++; $display("FAIL restart_d1_n_out: got %h want 0", n_out); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        value_in    = 16'h0000;
        load        = 1'b0;
        digit_en    = 4'b1111;
        dp_in       = 4'b0000;
        blank_lz    = 1'b0;

        test_reset();
        test_load_midframe();
        test_lz();
        test_boundary_load();
        test_enable_dp();
        test_reset_midrun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
